truth_table_scanner: RTL and testbench

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

---
 rtl/ttscan_pkg.sv | 30 +++
 rtl/ttscan_settle_cnt.sv | 44 ++++
 rtl/truth_table_scanner.sv | 152 +++++++++++++++
 tb/tb_truth_table_scanner.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ttscan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ttscan_pkg
// Description : Shared constants and FSM encoding for the truth-table scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package ttscan_pkg;

  // Exhaustive scan of a 4-input function
  localparam int NUM_VECTORS = 16;
  localparam int IDX_W       = 4;
  localparam int CNT_W       = 5;
  localparam int SETTLE_W    = 4;

  // FSM encoding
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Index of the final vector; reaching it in SAMPLE ends the scan
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

  // True while the function under test is being driven and observed
  function automatic logic scan_active(input logic [1:0] st);
    return (st == ST_SETTLE) || (st == ST_SAMPLE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ttscan_settle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : ttscan_settle_cnt
// Description : Loadable down-counter timing how long each vector is held.
//               tc_o is high whenever the count has reached zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ttscan_settle_cnt #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Load takes priority; otherwise count down while enabled, saturating at 0
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scanner
// Description : Walks all 16 input combinations of a 4-input combinational
//               function, captures its output per vector and compares it
//               against a golden minterm mask.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_scanner
  import ttscan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  mismatch_count,
  output logic [3:0]  first_fail,
  output logic        pass
);

  // Counter is loaded with N-1 so that SETTLE lasts exactly N cycles
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [1:0]             state_q,  state_d;
  logic [IDX_W-1:0]       index_q,  index_d;
  logic [NUM_VECTORS-1:0] exp_q,    exp_d;
  logic [NUM_VECTORS-1:0] table_q,  table_d;
  logic [CNT_W-1:0]       mcount_q, mcount_d;
  logic [IDX_W-1:0]       ffail_q,  ffail_d;

  logic settle_load;
  logic settle_tc;
  logic active;

  ttscan_settle_cnt #(
    .WIDTH (SETTLE_W)
  ) u_settle_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (settle_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (state_q == ST_SETTLE),
    .tc_o       (settle_tc)
  );

  // Next-state and result-update logic for the scan sequencer
  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    exp_d       = exp_q;
    table_d     = table_q;
    mcount_d    = mcount_q;
    ffail_d     = ffail_q;
    settle_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort alongside start keeps the block idle and results untouched
        if (start && !abort) begin
          exp_d       = expected;
          table_d     = '0;
          mcount_d    = '0;
          ffail_d     = '0;
          index_d     = '0;
          state_d     = ST_SETTLE;
          settle_load = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (settle_tc) begin
          state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        // abort wins over capture: the aborted vector is not recorded
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          table_d[index_q] = f_in;
          if (f_in != exp_q[index_q]) begin
            mcount_d = mcount_q + CNT_W'(1);
            if (mcount_q == '0) begin
              ffail_d = index_q;
            end
          end
          if (index_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            index_d     = index_q + IDX_W'(1);
            state_d     = ST_SETTLE;
            settle_load = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset forces idle with a clean result set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      index_q  <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      mcount_q <= '0;
      ffail_q  <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      mcount_q <= mcount_d;
      ffail_q  <= ffail_d;
    end
  end

  // Stimulus is decoded from state so it drops to zero the moment the scan
  // stops (abort, done or reset) without an extra register stage
  assign active         = scan_active(state_q);
  assign {a, b, c, d}   = active ? index_q : '0;
  assign busy           = active;
  assign done           = (state_q == ST_DONE);
  assign table_out      = table_q;
  assign mismatch_count = mcount_q;
  assign first_fail     = ffail_q;
  assign pass           = (mcount_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_scanner
// Description : Scoreboard bench for truth_table_scanner. Each accepted scan
//               pushes its expected result; a monitor pops on every done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_scanner;

  typedef struct packed {
    logic [15:0] tbl;
    logic [4:0]  cnt;
    logic [3:0]  ff;
    logic        ps;
  } result_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        f_in;
  logic        a, b, c, d;
  logic        busy;
  logic        done;
  logic [15:0] table_out;
  logic [4:0]  mismatch_count;
  logic [3:0]  first_fail;
  logic        pass;

  // f_in model selection: 0 = golden table, 1 = stuck at 0, 2 = a&b&c&d
  logic [1:0]  mode;
  logic [15:0] golden;
  logic [3:0]  w_vec;

  int n_vec;
  int n_miscompares;
  int done_count;

  result_t sb_q[$];

  truth_table_scanner #(
    .SETTLE_CYCLES (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .expected       (expected),
    .f_in           (f_in),
    .a              (a),
    .b              (b),
    .c              (c),
    .d              (d),
    .busy           (busy),
    .done           (done),
    .table_out      (table_out),
    .mismatch_count (mismatch_count),
    .first_fail     (first_fail),
    .pass           (pass)
  );

  assign w_vec = {a, b, c, d};
  assign f_in  = (mode == 2'd0) ? golden[w_vec] :
                 (mode == 2'd1) ? 1'b0 : (a & b & c & d);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miscompares++;
        $display("FAIL unexpected_done: got done=1, want no done (no scan outstanding)");
      end else begin
        result_t r;
        r = sb_q.pop_front();
        check("sb_table_out", 32'(table_out), 32'(r.tbl));
        check("sb_mismatch_count", 32'(mismatch_count), 32'(r.cnt));
        check("sb_first_fail", 32'(first_fail), 32'(r.ff));
        check("sb_pass", 32'(pass), 32'(r.ps));
        check("sb_abcd_in_done", 32'(w_vec), 32'd0);
        check("sb_busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  // Pulse start so that it is sampled by exactly one rising edge
  task automatic start_scan();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges after the start edge until done is seen; -1 on timeout
  task automatic wait_done(input int first, output int lat);
    lat = -1;
    for (int i = first; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic push(input logic [15:0] t, input logic [4:0] n, input logic [3:0] f);
    result_t r;
    r.tbl = t;
    r.cnt = n;
    r.ff  = f;
    r.ps  = (n == 5'd0);
    sb_q.push_back(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int dc;
    n_vec         = 0;
    n_miscompares = 0;
    done_count    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    expected = 16'h0000;
    mode     = 2'd0;
    golden   = 16'h0000;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_table", 32'(table_out), 32'd0);
    check("rst_count", 32'(mismatch_count), 32'd0);
    check("rst_first_fail", 32'(first_fail), 32'd0);
    check("rst_pass", 32'(pass), 32'd1);
    check("rst_abcd", 32'(w_vec), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Golden function matches expected mask
    mode = 2'd0; golden = 16'hA5C3; expected = 16'hA5C3;
    push(16'hA5C3, 5'd0, 4'd0);
    start_scan();
    check("busy_after_start", 32'(busy), 32'd1);
    wait_done(1, lat);
    check("latency_match", 32'(lat), 32'd48);
    repeat (5) @(negedge clk);
    check("hold_table", 32'(table_out), 32'hA5C3);
    check("hold_pass", 32'(pass), 32'd1);

    // Stuck-at-0 function
    mode = 2'd1;
    push(16'h0000, 5'd8, 4'd0);
    start_scan();
    wait_done(1, lat);
    check("latency_stuck0", 32'(lat), 32'd48);
    repeat (3) @(negedge clk);

    // AND4 function against a mask with one flipped bit
    mode = 2'd2; expected = 16'h8008;
    push(16'h8000, 5'd1, 4'd3);
    start_scan();
    wait_done(1, lat);
    check("latency_and4", 32'(lat), 32'd48);
    repeat (3) @(negedge clk);

    // Abort sampled on edge 10 after start: vectors 0..2 already captured
    mode = 2'd0; golden = 16'hA5C3; expected = 16'hA5C3;
    dc = done_count;
    start_scan();
    repeat (9) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_abcd", 32'(w_vec), 32'd0);
    check("abort_partial_table", 32'(table_out), 32'h0003);
    check("abort_partial_count", 32'(mismatch_count), 32'd0);
    repeat (60) @(negedge clk);
    check("abort_no_done", 32'(done_count), 32'(dc));
    push(16'hA5C3, 5'd0, 4'd0);
    start_scan();
    wait_done(1, lat);
    check("latency_after_abort", 32'(lat), 32'd48);
    repeat (3) @(negedge clk);

    // abort together with start in IDLE stays idle
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    check("start_abort_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("start_abort_no_clear", 32'(table_out), 32'hA5C3);

    // Extra start at edge 5 and in the DONE cycle are both ignored
    mode = 2'd1; expected = 16'h0000;
    dc = done_count;
    push(16'h0000, 5'd0, 4'd0);
    start_scan();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(6, lat);
    check("latency_restart_ignored", 32'(lat), 32'd48);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("done_start_ignored_busy", 32'(busy), 32'd0);
    repeat (60) @(negedge clk);
    check("single_done", 32'(done_count), 32'(dc + 1));

    // Asynchronous reset mid-scan
    mode = 2'd2; expected = 16'h8008;
    dc = done_count;
    start_scan();
    repeat (20) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_abcd", 32'(w_vec), 32'd0);
    check("arst_table", 32'(table_out), 32'd0);
    check("arst_count", 32'(mismatch_count), 32'd0);
    check("arst_pass", 32'(pass), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (70) @(negedge clk);
    check("arst_no_resume_busy", 32'(busy), 32'd0);
    check("arst_no_done", 32'(done_count), 32'(dc));

    // A fresh start after reset completes normally
    push(16'h8000, 5'd1, 4'd3);
    start_scan();
    wait_done(1, lat);
    check("latency_after_reset", 32'(lat), 32'd48);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompares);
    $finish;
  end

endmodule
`default_nettype wire
